// File: rtl/lcd_fetch_arbiter.sv
// Framebuffer SRAM arbiter: pixel FIFO refill reads vs GPU writes, grant is combinational.
// Reads return MEM_LAT cycles later as fifo_push; GPU requests wait (held) while refill wins.
module lcd_fetch_arbiter #(
  parameter int H_PIX        = 480,
  parameter int V_PIX        = 272,
  parameter int ADDR_W       = 18,
  parameter int FB_STRIDE    = 131072,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_WM       = 4,
  parameter int HIGH_WM      = 12,
  parameter int MAX_WR_BURST = 8,
  parameter int MEM_LAT      = 2
) (
  input  logic              clk_12mhz,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              fb_sel,
  input  logic [4:0]        fifo_level,
  output logic              fifo_push,
  output logic [23:0]       fifo_data,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [23:0]       gpu_data,
  output logic              gpu_ack,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun
);

  localparam int NPIX  = H_PIX * V_PIX;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int STK_W = $clog2(MAX_WR_BURST + 1);

  localparam logic [5:0]       LOW6   = 6'(LOW_WM);
  localparam logic [5:0]       HIGH6  = 6'(HIGH_WM);
  localparam logic [5:0]       DEPTH6 = 6'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NPIX - 1);
  localparam logic [STK_W-1:0] MAXB   = STK_W'(MAX_WR_BURST);

  typedef enum logic [1:0] {IDLE, PREFILL, ACTIVE, DRAIN} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    pix_cnt;
  logic [MEM_LAT-1:0]  rd_sr;
  logic [STK_W-1:0]    streak;
  logic [5:0]          inflight;
  logic [5:0]          eff;
  logic                rd_go;
  logic                wr_go;
  logic                done;
  logic [ADDR_W-1:0]   rd_addr;

  // eff counts pixels that will land in the FIFO, so refill never overshoots
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + {5'd0, rd_sr[i]};
    end
    eff = {1'b0, fifo_level} + inflight;
  end

  assign rd_addr = base + ADDR_W'(pix_cnt);

  always_comb begin
    next_state = state;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        wr_go = gpu_req;
        if (frame_start) next_state = PREFILL;
      end
      PREFILL: begin
        // Once the watermark is reached this cycle already arbitrates like ACTIVE
        if (eff < HIGH6) begin
          rd_go = (eff < DEPTH6);
        end else begin
          wr_go      = gpu_req;
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (eff < LOW6) begin
          rd_go = (eff < DEPTH6);
        end else if (gpu_req && ((streak < MAXB) || (eff >= HIGH6))) begin
          wr_go = 1'b1;
        end else if (eff < HIGH6) begin
          rd_go = (eff < DEPTH6);
        end
      end
      DRAIN: begin
        wr_go = gpu_req;
        if (inflight == 6'd0) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (rd_go && (pix_cnt == LAST)) next_state = DRAIN;
  end

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      base    <= '0;
      pix_cnt <= '0;
      rd_sr   <= '0;
      streak  <= '0;
    end else begin
      state <= next_state;
      rd_sr <= (rd_sr << 1) | MEM_LAT'(rd_go);
      if ((state == IDLE) && frame_start) begin
        base    <= fb_sel ? ADDR_W'(FB_STRIDE) : '0;
        pix_cnt <= '0;
      end else if (rd_go) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (rd_go) begin
        streak <= '0;
      end else if (wr_go && (streak < MAXB)) begin
        streak <= streak + STK_W'(1);
      end
    end
  end

  assign fifo_push     = rd_sr[MEM_LAT-1];
  assign fifo_data     = fifo_push ? mem_rdata : '0;
  assign gpu_ack       = wr_go;
  assign mem_valid     = wr_go | rd_go;
  assign mem_we        = wr_go;
  assign mem_addr      = wr_go ? gpu_addr : (rd_go ? rd_addr : '0);
  assign mem_wdata     = wr_go ? gpu_data : '0;
  assign busy          = (state != IDLE) && !done;
  assign frame_done    = done;
  assign frame_overrun = frame_start && (state != IDLE);

endmodule

// File: tb/tb_lcd_fetch_arbiter.sv
// Bench for lcd_fetch_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_lcd_fetch_arbiter;

  localparam int AW     = 18;
  localparam int STRIDE = 131072;
  localparam int BNPIX  = 16 * 8;
  localparam int LAT    = 2;
  localparam int LOWW   = 4;
  localparam int HIGHW  = 12;
  localparam int DEPTH  = 16;
  localparam int MAXB   = 8;

  logic clk_12mhz = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  logic          frame_start = 1'b0, fb_sel = 1'b0, gpu_req = 1'b0;
  logic [4:0]    fifo_level = '0;
  logic [AW-1:0] gpu_addr = '0;
  logic [23:0]   gpu_data = '0, mem_rdata = '0;
  logic          fifo_push, gpu_ack, mem_valid, mem_we, busy, frame_done, frame_overrun;
  logic [23:0]   fifo_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          s_frame_start = 1'b0, s_fb_sel = 1'b0, s_gpu_req = 1'b0;
  logic [4:0]    s_fifo_level = '0;
  logic [AW-1:0] s_gpu_addr = '0;
  logic [23:0]   s_gpu_data = '0, s_mem_rdata = '0;
  logic          s_fifo_push, s_gpu_ack, s_mem_valid, s_mem_we, s_busy, s_frame_done, s_frame_overrun;
  logic [23:0]   s_fifo_data, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_fetch_arbiter #(.H_PIX(16), .V_PIX(8)) u_dut (
    .clk_12mhz(clk_12mhz), .reset_n(reset_n), .frame_start(frame_start), .fb_sel(fb_sel),
    .fifo_level(fifo_level), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_data(gpu_data), .gpu_ack(gpu_ack),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  lcd_fetch_arbiter #(.H_PIX(4), .V_PIX(2)) u_small (
    .clk_12mhz(clk_12mhz), .reset_n(reset_n), .frame_start(s_frame_start), .fb_sel(s_fb_sel),
    .fifo_level(s_fifo_level), .fifo_push(s_fifo_push), .fifo_data(s_fifo_data),
    .gpu_req(s_gpu_req), .gpu_addr(s_gpu_addr), .gpu_data(s_gpu_data), .gpu_ack(s_gpu_ack),
    .mem_valid(s_mem_valid), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .busy(s_busy), .frame_done(s_frame_done), .frame_overrun(s_frame_overrun)
  );

  function automatic logic [72:0] big_outs();
    return {fifo_push, fifo_data, gpu_ack, mem_valid, mem_we, mem_addr, mem_wdata,
            busy, frame_done, frame_overrun};
  endfunction

  function automatic logic [72:0] small_outs();
    return {s_fifo_push, s_fifo_data, s_gpu_ack, s_mem_valid, s_mem_we, s_mem_addr, s_mem_wdata,
            s_busy, s_frame_done, s_frame_overrun};
  endfunction

  task automatic next_cycle();
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_12mhz);
    n_tests++;
    if (big_outs() !== '0) begin n_fail++; $display("FAIL reset_big: got %h expected 0", big_outs()); end
    n_tests++;
    if (small_outs() !== '0) begin n_fail++; $display("FAIL reset_small: got %h expected 0", small_outs()); end
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk_12mhz);
    n_tests++;
    if (big_outs() !== '0) begin n_fail++; $display("FAIL reset_release: got %h expected 0", big_outs()); end
    next_cycle();
  endtask

  task automatic test_small_frame();
    int rd_cyc[$];
    int rd_adr[$];
    int push_cyc[$];
    int done_cyc = -1;
    for (int c = 0; c < 30 && done_cyc < 0; c++) begin
      s_frame_start = (c == 0);
      s_fb_sel      = (c == 0);
      s_mem_rdata   = 24'($urandom);
      @(negedge clk_12mhz);
      if (s_mem_valid && !s_mem_we) begin rd_cyc.push_back(c); rd_adr.push_back(int'(s_mem_addr)); end
      if (s_fifo_push) begin
        push_cyc.push_back(c);
        n_tests++;
        if (s_fifo_data !== s_mem_rdata) begin
          n_fail++; $display("FAIL small_data: got %h expected %h", s_fifo_data, s_mem_rdata);
        end
      end
      if (s_frame_done) done_cyc = c;
      next_cycle();
    end
    n_tests++;
    if (rd_cyc.size() != 8 || push_cyc.size() != 8) begin
      n_fail++; $display("FAIL small_counts: got %0d reads %0d pushes expected 8 8", rd_cyc.size(), push_cyc.size());
    end
    for (int i = 0; i < 8 && i < rd_cyc.size(); i++) begin
      n_tests++;
      if (rd_cyc[i] != i + 1 || rd_adr[i] != STRIDE + i) begin
        n_fail++; $display("FAIL small_read%0d: got cyc %0d addr %0d expected cyc %0d addr %0d",
                           i, rd_cyc[i], rd_adr[i], i + 1, STRIDE + i);
      end
      if (i < push_cyc.size()) begin
        n_tests++;
        if (push_cyc[i] != i + 1 + LAT) begin
          n_fail++; $display("FAIL small_push%0d: got cyc %0d expected %0d", i, push_cyc[i], i + 1 + LAT);
        end
      end
    end
    n_tests++;
    if (done_cyc != 11) begin n_fail++; $display("FAIL small_done: got cyc %0d expected 11", done_cyc); end
    @(negedge clk_12mhz);
    n_tests++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL small_busy_after: got %b expected 0", s_busy); end
    next_cycle();
  endtask

  task automatic test_prefill_block();
    int lvl = 0;
    int reads = 0;
    int ack_reads = -1;
    frame_start = 1'b1; fb_sel = 1'b0; gpu_req = 1'b1; fifo_level = '0;
    gpu_addr = AW'($urandom); gpu_data = 24'($urandom);
    @(negedge clk_12mhz);
    n_tests++;
    if (!(gpu_ack === 1'b1 && mem_we === 1'b1 && mem_addr === gpu_addr)) begin
      n_fail++; $display("FAIL start_cycle_grant: got ack %b we %b expected 1 1", gpu_ack, mem_we);
    end
    for (int c = 0; c < 40 && ack_reads < 0; c++) begin
      next_cycle();
      frame_start = 1'b0;
      fifo_level  = 5'(lvl);
      @(negedge clk_12mhz);
      if (gpu_ack === 1'b1) ack_reads = reads;
      else if (mem_valid === 1'b1 && mem_we === 1'b0) begin
        n_tests++;
        if (mem_addr !== AW'(reads)) begin
          n_fail++; $display("FAIL prefill_addr: got %0d expected %0d", mem_addr, reads);
        end
        reads++;
      end
      if (fifo_push === 1'b1) lvl++;
    end
    n_tests++;
    if (ack_reads != 12) begin n_fail++; $display("FAIL prefill_block: got ack after %0d reads expected 12", ack_reads); end
    next_cycle();
  endtask

  task automatic test_burst_cap();
    int kind;
    int exp_kind;
    gpu_req = 1'b0; fifo_level = 5'd8;
    repeat (3) next_cycle();
    gpu_req = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_12mhz);
      kind     = (gpu_ack && mem_valid && mem_we) ? 1 : ((mem_valid && !mem_we && !gpu_ack) ? 2 : 0);
      exp_kind = (c == 8) ? 2 : 1;
      n_tests++;
      if (kind != exp_kind) begin n_fail++; $display("FAIL burst_cap%0d: got kind %0d expected %0d", c, kind, exp_kind); end
      next_cycle();
    end
  endtask

  task automatic test_urgent();
    fifo_level = 5'd3;
    @(negedge clk_12mhz);
    n_tests++;
    if (!(mem_valid === 1'b1 && mem_we === 1'b0 && gpu_ack === 1'b0)) begin
      n_fail++; $display("FAIL urgent: got valid %b we %b ack %b expected 1 0 0", mem_valid, mem_we, gpu_ack);
    end
    next_cycle();
  endtask

  task automatic test_overrun();
    logic [AW-1:0] exp_a;
    gpu_req = 1'b0; fifo_level = 5'd8;
    for (int c = 0; c < 3; c++) begin
      frame_start = (c == 1);
      fb_sel      = (c == 1);
      exp_a       = AW'(17 + c);
      @(negedge clk_12mhz);
      n_tests++;
      if (!(frame_overrun === (c == 1) && mem_valid === 1'b1 && mem_we === 1'b0 && mem_addr === exp_a && busy === 1'b1)) begin
        n_fail++; $display("FAIL overrun%0d: got ovr %b addr %0d busy %b expected ovr %b addr %0d busy 1",
                           c, frame_overrun, mem_addr, busy, c == 1, exp_a);
      end
      next_cycle();
    end
    frame_start = 1'b0; fb_sel = 1'b0;
  endtask

  task automatic test_reset_midframe();
    #1 reset_n = 1'b0;
    @(negedge clk_12mhz);
    n_tests++;
    if (big_outs() !== '0) begin n_fail++; $display("FAIL midframe_reset: got %h expected 0", big_outs()); end
    next_cycle();
    reset_n = 1'b1; fifo_level = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_12mhz);
      n_tests++;
      if ({fifo_push, mem_valid, busy, gpu_ack} !== 4'b0) begin
        n_fail++; $display("FAIL post_reset%0d: got push/valid/busy/ack %b expected 0000", c, {fifo_push, mem_valid, busy, gpu_ack});
      end
      next_cycle();
    end
    gpu_req = 1'b1;
    @(negedge clk_12mhz);
    n_tests++;
    if (!(gpu_ack === 1'b1 && mem_we === 1'b1)) begin n_fail++; $display("FAIL post_reset_idle_grant: got ack %b expected 1", gpu_ack); end
    next_cycle();
    gpu_req = 1'b0;
  endtask

  task automatic test_random();
    bit m_busy = 0, m_prefill = 0, accept, e_rd, e_wr, e_push, e_done, held;
    int m_reads = 0, m_base = 0, m_streak = 0, inflight, eff;
    int q[$];
    logic [72:0] exp;
    reset_n = 1'b0; gpu_req = 1'b0; frame_start = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    held = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      frame_start = ($urandom_range(0, 39) == 0);
      fb_sel      = 1'($urandom);
      fifo_level  = 5'($urandom_range(0, 16));
      mem_rdata   = 24'($urandom);
      if (!held) begin
        gpu_req  = ($urandom_range(0, 2) != 0);
        gpu_addr = AW'($urandom);
        gpu_data = 24'($urandom);
      end
      @(negedge clk_12mhz);
      inflight = q.size();
      eff      = int'(fifo_level) + inflight;
      e_push   = (q.size() > 0) && (q[0] == cyc - LAT);
      e_rd = 0; e_wr = 0; e_done = 0;
      if (!m_busy) e_wr = gpu_req;
      else if (m_reads == BNPIX) begin e_wr = gpu_req; e_done = (inflight == 0); end
      else if (m_prefill && eff < HIGHW) e_rd = 1;
      else if (eff < LOWW) e_rd = 1;
      else if (gpu_req && (m_streak < MAXB || eff >= HIGHW)) e_wr = 1;
      else if (eff < HIGHW) e_rd = 1;
      if (eff >= DEPTH) e_rd = 0;
      exp = {e_push, e_push ? mem_rdata : 24'd0, e_wr, e_wr | e_rd, e_wr,
             e_wr ? gpu_addr : (e_rd ? AW'(m_base + m_reads) : AW'(0)),
             e_wr ? gpu_data : 24'd0, m_busy && !e_done, e_done, frame_start && m_busy};
      n_tests++;
      if (big_outs() !== exp) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, big_outs(), exp);
      end
      held   = gpu_req && !gpu_ack;
      accept = frame_start && !m_busy;
      if (e_push) void'(q.pop_front());
      if (e_rd) begin q.push_back(cyc); m_reads++; m_streak = 0; end
      else if (e_wr && m_streak < MAXB) m_streak++;
      if (m_busy && m_prefill && eff >= HIGHW) m_prefill = 0;
      if (e_done) m_busy = 0;
      if (accept) begin m_busy = 1; m_prefill = 1; m_reads = 0; m_base = fb_sel ? STRIDE : 0; end
      next_cycle();
    end
    gpu_req = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_prefill_block();
    test_burst_cap();
    test_urgent();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
